// File: rtl/invader_formation_if.sv
// Pixel-stream, kill-request and formation-status bundle between the
// timing/collision stages (master) and invader_formation (slave).
interface invader_formation_if #(
  parameter int CORDW = 16,
  parameter int ROWS  = 5,
  parameter int COLS  = 11
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int NW = $clog2(ROWS*COLS+1);

  logic                    frame;
  logic                    de;
  logic signed [CORDW-1:0] sx;
  logic signed [CORDW-1:0] sy;
  logic                    kill_valid;
  logic [RW-1:0]           kill_row;
  logic [CW-1:0]           kill_col;
  logic                    paint;
  logic [RW-1:0]           hit_row;
  logic [CW-1:0]           hit_col;
  logic signed [CORDW-1:0] grid_x;
  logic signed [CORDW-1:0] grid_y;
  logic [NW-1:0]           alive_cnt;
  logic                    landed;
  logic                    cleared;

  modport master (
    output frame, de, sx, sy, kill_valid, kill_row, kill_col,
    input  paint, hit_row, hit_col, grid_x, grid_y, alive_cnt, landed, cleared
  );

  modport slave (
    input  frame, de, sx, sy, kill_valid, kill_row, kill_col,
    output paint, hit_row, hit_col, grid_x, grid_y, alive_cnt, landed, cleared
  );
endinterface

// File: rtl/invader_formation.sv
// Invader formation state (alive mask, origin, march direction, animation)
// with the classic march FSM and a registered per-pixel "invader here" flag.
module invader_formation #(
  parameter int CORDW    = 16,
  parameter int ROWS     = 5,
  parameter int COLS     = 11,
  parameter int SPR_W    = 16,
  parameter int SPR_H    = 8,
  parameter int GAP_X    = 8,
  parameter int GAP_Y    = 8,
  parameter int START_X  = 64,
  parameter int START_Y  = 48,
  parameter int STEP_X   = 4,
  parameter int STEP_Y   = 8,
  parameter int MOVE_DIV = 30,
  parameter int X_MAX    = 640,
  parameter int Y_LIMIT  = 440,
  parameter logic [SPR_W*SPR_H-1:0] SPR0 = '1,
  parameter logic [SPR_W*SPR_H-1:0] SPR1 = '1
) (
  input logic          clk_pix,
  input logic          rst_pix,
  invader_formation_if.slave bus
);
  localparam int PX    = SPR_W + GAP_X;
  localparam int PY    = SPR_H + GAP_Y;
  localparam int CELLS = ROWS * COLS;
  localparam int RW    = $clog2(ROWS);
  localparam int CW    = $clog2(COLS);
  localparam int NW    = $clog2(CELLS + 1);
  localparam int AW    = $clog2(CELLS);
  localparam int SW    = $clog2(SPR_W * SPR_H);
  localparam int DW    = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

  localparam logic signed [CORDW-1:0] START_XS = CORDW'(START_X);
  localparam logic signed [CORDW-1:0] START_YS = CORDW'(START_Y);
  localparam logic signed [CORDW-1:0] STEP_XS  = CORDW'(STEP_X);
  localparam logic signed [CORDW-1:0] STEP_YS  = CORDW'(STEP_Y);
  localparam logic signed [CORDW-1:0] X_MAX_S  = CORDW'(X_MAX);
  localparam logic signed [CORDW-1:0] Y_LIM_S  = CORDW'(Y_LIMIT);
  localparam logic signed [CORDW-1:0] SPR_WS   = CORDW'(SPR_W);
  localparam logic signed [CORDW-1:0] SPR_HS   = CORDW'(SPR_H);
  localparam logic signed [CORDW-1:0] BOT_OFF  = CORDW'((ROWS-1)*PY + SPR_H);
  localparam logic [DW-1:0]           DIV_LAST = DW'(MOVE_DIV - 1);
  localparam logic [NW-1:0]           CNT_FULL = NW'(CELLS);

  typedef enum logic [1:0] {MOVE_R, MOVE_L, LANDED, CLEARED} state_t;

  state_t                  state, state_n;
  logic signed [CORDW-1:0] grid_x, grid_y, grid_x_n, grid_y_n;
  logic                    anim, anim_n;
  logic [DW-1:0]           div_q;
  logic                    tick;
  logic [CELLS-1:0]        alive;
  logic [NW-1:0]           alive_cnt;
  logic                    kill_ok;
  logic [AW-1:0]           kill_idx;
  logic [COLS-1:0]         col_any;
  logic [CW-1:0]           lcol, rcol;
  logic                    seen;
  logic signed [CORDW-1:0] edge_l, edge_r, left_pos, gy_step;
  logic                    right_over, left_under, land_hit;
  logic                    paint_q, landed_o, cleared_o;
  logic [RW-1:0]           hit_row_q, pr;
  logic [CW-1:0]           hit_col_q, pc;

  assign tick = bus.frame && (div_q == DIV_LAST);

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix)        div_q <= '0;
    else if (bus.frame) div_q <= (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
  end

  // Marching edges come from the occupied column span of the current mask.
  always_comb begin
    col_any = '0;
    for (int unsigned c = 0; c < COLS; c++)
      for (int unsigned r = 0; r < ROWS; r++)
        col_any[c] = col_any[c] | alive[r*COLS + c];
    lcol = '0;
    rcol = '0;
    seen = 1'b0;
    for (int unsigned c = 0; c < COLS; c++) begin
      if (col_any[c]) begin
        rcol = CW'(c);
        if (!seen) lcol = CW'(c);
        seen = 1'b1;
      end
    end
    edge_l     = grid_x + CORDW'(32'(lcol) * PX);
    edge_r     = grid_x + CORDW'(32'(rcol) * PX) + SPR_WS;
    left_pos   = edge_l - STEP_XS;
    left_under = left_pos[CORDW-1];
    right_over = (edge_r + STEP_XS) > X_MAX_S;
    gy_step    = grid_y + STEP_YS;
    land_hit   = (gy_step + BOT_OFF) >= Y_LIM_S;
  end

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) state <= MOVE_R;
    else         state <= state_n;
  end

  always_comb begin
    state_n  = state;
    grid_x_n = grid_x;
    grid_y_n = grid_y;
    anim_n   = anim;
    case (state)
      MOVE_R, MOVE_L: begin
        if (alive_cnt == '0) begin
          state_n = CLEARED;
        end else if (tick) begin
          anim_n = ~anim;
          if ((state == MOVE_R) ? right_over : left_under) begin
            grid_y_n = gy_step;
            state_n  = land_hit ? LANDED : ((state == MOVE_R) ? MOVE_L : MOVE_R);
          end else begin
            grid_x_n = (state == MOVE_R) ? grid_x + STEP_XS : grid_x - STEP_XS;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    landed_o  = (state == LANDED);
    cleared_o = (state == CLEARED);
  end

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      grid_x <= START_XS;
      grid_y <= START_YS;
      anim   <= 1'b0;
    end else begin
      grid_x <= grid_x_n;
      grid_y <= grid_y_n;
      anim   <= anim_n;
    end
  end

  always_comb begin
    kill_idx = AW'(32'(bus.kill_row) * COLS + 32'(bus.kill_col));
    kill_ok  = bus.kill_valid && (32'(bus.kill_row) < ROWS) &&
               (32'(bus.kill_col) < COLS) && alive[kill_idx];
  end

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      alive     <= '1;
      alive_cnt <= CNT_FULL;
    end else if (kill_ok) begin
      alive[kill_idx] <= 1'b0;
      alive_cnt       <= alive_cnt - 1'b1;
    end
  end

  logic signed [CORDW-1:0]   dx, dy, cx, cy, rx, ry;
  logic                      col_hit, row_hit, pix_on;
  logic [SPR_W*SPR_H-1:0]    spr_bits;
  logic [AW-1:0]             cell_idx;
  logic [SW-1:0]             spr_idx;

  // Cell lookup by parallel window compares against each column/row pitch.
  always_comb begin
    dx      = bus.sx - grid_x;
    dy      = bus.sy - grid_y;
    col_hit = 1'b0;
    row_hit = 1'b0;
    pc      = '0;
    pr      = '0;
    rx      = '0;
    ry      = '0;
    cx      = '0;
    cy      = '0;
    for (int unsigned c = 0; c < COLS; c++) begin
      cx = CORDW'(c * PX);
      if (dx >= cx && dx < cx + SPR_WS) begin
        col_hit = 1'b1;
        pc      = CW'(c);
        rx      = dx - cx;
      end
    end
    for (int unsigned r = 0; r < ROWS; r++) begin
      cy = CORDW'(r * PY);
      if (dy >= cy && dy < cy + SPR_HS) begin
        row_hit = 1'b1;
        pr      = RW'(r);
        ry      = dy - cy;
      end
    end
    spr_bits = anim ? SPR1 : SPR0;
    cell_idx = AW'(32'(pr) * COLS + 32'(pc));
    spr_idx  = SW'(32'(ry) * SPR_W + 32'(rx));
    pix_on   = bus.de && col_hit && row_hit && alive[cell_idx] &&
               spr_bits[spr_idx] && (state != CLEARED);
  end

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      paint_q   <= 1'b0;
      hit_row_q <= '0;
      hit_col_q <= '0;
    end else begin
      paint_q <= pix_on;
      if (pix_on) begin
        hit_row_q <= pr;
        hit_col_q <= pc;
      end
    end
  end

  assign bus.paint     = paint_q;
  assign bus.hit_row   = hit_row_q;
  assign bus.hit_col   = hit_col_q;
  assign bus.grid_x    = grid_x;
  assign bus.grid_y    = grid_y;
  assign bus.alive_cnt = alive_cnt;
  assign bus.landed    = landed_o;
  assign bus.cleared   = cleared_o;
endmodule
